adler32_multilane: RTL and testbench
====================================

ADLER32_MULTILANE -- requirements
Module: adler32_multilane

Interface
REQ-001 SHALL have parameter LANES, default 1, bytes accepted per data beat; legal values 1, 2, 4.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port size_valid  input  1  qualifies size; starts a message.
REQ-005 SHALL have port size  input  32  message length in bytes.
REQ-006 SHALL have port data_valid  input  1  qualifies data.
REQ-007 SHALL have port data  input  8*LANES  message bytes; data[7:0] is the earliest byte, then ascending lanes.
REQ-008 SHALL have port checksum_valid  output  1  one-cycle pulse marking checksum.
REQ-009 SHALL have port checksum  output  32  Adler-32 result {B[15:0], A[15:0]}.

Function
REQ-010 SHALL implement FSM IDLE/DATA; reset state IDLE.
REQ-011 IDLE + size_valid, size!=0: SHALL latch remaining=size, A=1, B=0, go DATA.
REQ-012 IDLE + size_valid, size==0: SHALL stay IDLE, drive checksum=0x00000001 with checksum_valid the following cycle.
REQ-013 DATA + data_valid: SHALL consume n=min(LANES, remaining) lanes in lane order, per byte A=(A+byte) mod 65521 then B=(B+A) mod 65521; lanes >= n ignored.
REQ-014 Modular reduction SHALL be one conditional subtract of 65521 per add (A<65521, B<65521 invariants); no divider.
REQ-015 DATA SHALL decrement remaining by n per accepted beat; beat with remaining<=LANES is final.
REQ-016 On final beat SHALL register checksum and assert checksum_valid exactly one cycle later, return to IDLE on the same edge.
REQ-017 checksum SHALL hold its last value until the next checksum_valid; checksum_valid high exactly one cycle per message.
REQ-018 No backpressure: gaps (data_valid low) in DATA SHALL be tolerated indefinitely without state change.
REQ-019 size_valid while in DATA (including on the final beat) SHALL be ignored.
REQ-020 data_valid while in IDLE, including with size_valid in the same cycle, SHALL be ignored.
REQ-021 size_valid in the cycle checksum_valid is high SHALL start a new message (back-to-back).
REQ-022 size is 32 bits; remaining counter SHALL be 32 bits, no wrap below zero.

Reset
REQ-023 rst_n low at a clock edge SHALL force IDLE, checksum=0, checksum_valid=0, A=1, B=0, remaining=0, regardless of message in progress.
REQ-024 A message interrupted by reset SHALL produce no checksum_valid.

Configuration
REQ-025 Macro ADLER32_MULTILANE_ERR_EN defined: SHALL add output port err (1 bit), a one-cycle pulse on size_valid in DATA or data_valid in IDLE; reset value 0.
REQ-026 Macro undefined: err port absent; those events silently ignored per REQ-019/020.

Structure
REQ-027 Package adler32_pkg SHALL hold MOD_ADLER=16'd65521, A_INIT=16'd1, and the FSM state typedef.
REQ-028 Per-byte update SHALL be sub-module adler32_byte_step (A,B,byte in; A',B' out, combinational), instantiated LANES times in a chain.

Verification
REQ-029 Bench (tb_player-driven, Multi_msg style) SHALL cover, for LANES=1 and 4:
- size=0 -> checksum_valid next cycle, checksum=0x00000001.
- "abc" (size=3; LANES=4 one beat, lane3 garbage 0xFF) -> checksum=0x024D0127, one pulse.
- "Wikipedia" (size=9; LANES=4 beats "Wiki","pedi","a"+3 garbage lanes, idle gaps between beats) -> 0x11E60398.
- Back-to-back: "abc" then "Wikipedia", second size_valid in checksum_valid cycle -> 0x024D0127 then 0x11E60398.
- rst_n low mid-"Wikipedia" after 4 bytes, then "abc" -> no pulse for aborted message, then 0x024D0127.
- With ADLER32_MULTILANE_ERR_EN: size_valid during DATA -> err one-cycle pulse, checksum unchanged from the undisturbed message.

Source files
------------

// File: rtl/adler32_pkg.sv
// ---------------------------------------------------------------------------
// adler32_pkg
// Shared constants, FSM state type and modular-add helper for the
// multi-lane Adler-32 engine.
//
// Contents:
//   MOD_ADLER  - Adler-32 modulus (largest prime below 2^16)
//   A_INIT     - initial value of the A running sum
//   state_t    - message FSM state (IDLE / DATA)
//   mod_add    - (x + y) mod MOD_ADLER for x, y < MOD_ADLER, no divider
// ---------------------------------------------------------------------------
package adler32_pkg;

    localparam logic [15:0] MOD_ADLER = 16'd65521;
    localparam logic [15:0] A_INIT    = 16'd1;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // Both operands are already reduced, so the sum is below 2*MOD_ADLER and
    // a single conditional subtract brings it back into range.
    function automatic logic [15:0] mod_add(input logic [15:0] x,
                                            input logic [15:0] y);
        logic [16:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, MOD_ADLER}) begin
            sum = sum - {1'b0, MOD_ADLER};
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/adler32_byte_step.sv
// ---------------------------------------------------------------------------
// adler32_byte_step
// Combinational Adler-32 update for a single message byte:
//   A' = (A + byte) mod 65521
//   B' = (B + A')   mod 65521
//
// Ports:
//   a_in      [15:0] in   current A sum (< 65521)
//   b_in      [15:0] in   current B sum (< 65521)
//   data_byte [7:0]  in   message byte
//   a_out     [15:0] out  updated A sum
//   b_out     [15:0] out  updated B sum
// ---------------------------------------------------------------------------
module adler32_byte_step
    import adler32_pkg::*;
(
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] a_out,
    output logic [15:0] b_out
);

    always_comb begin
        a_out = mod_add(a_in, {8'd0, data_byte});
        b_out = mod_add(b_in, a_out);
    end

endmodule

// File: rtl/adler32_multilane.sv
// ---------------------------------------------------------------------------
// adler32_multilane
// Adler-32 checksum engine accepting LANES bytes per data beat. A message
// starts with a size_valid/size pair, is followed by ceil(size/LANES) data
// beats (gaps allowed, no backpressure), and ends with a one-cycle
// checksum_valid pulse carrying {B, A}.
//
// Parameters:
//   LANES           bytes per data beat (1, 2 or 4)
//
// Ports:
//   clock           in   sole clock, rising edge
//   rst_n           in   synchronous active-low reset
//   size_valid      in   starts a message when idle
//   size    [31:0]  in   message length in bytes
//   data_valid      in   qualifies data while a message is in progress
//   data    [8*LANES-1:0] in  message bytes, data[7:0] earliest
//   checksum_valid  out  one-cycle pulse per message
//   checksum[31:0]  out  {B[15:0], A[15:0]}, held until the next pulse
//   err             out  (only with ADLER32_MULTILANE_ERR_EN) one-cycle pulse
//                        when size_valid arrives mid-message or data_valid
//                        arrives while idle
//
// Build option: define ADLER32_MULTILANE_ERR_EN to add the err output.
// ---------------------------------------------------------------------------
module adler32_multilane
    import adler32_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 size_valid,
    input  logic [31:0]          size,
    input  logic                 data_valid,
    input  logic [8*LANES-1:0]   data,
    output logic                 checksum_valid,
    output logic [31:0]          checksum
`ifdef ADLER32_MULTILANE_ERR_EN
    ,
    output logic                 err
`endif
);

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] checksum_q, checksum_d;
    logic        checksum_valid_q, checksum_valid_d;
`ifdef ADLER32_MULTILANE_ERR_EN
    logic        err_q, err_d;
`endif

    // Lane chain: element 0 is the registered sum, element i+1 is the sum
    // after lane i. Lanes past the end of the message pass the sum through
    // untouched so garbage bytes in the last beat have no effect.
    logic [LANES:0][15:0] a_chain;
    logic [LANES:0][15:0] b_chain;
    logic                 final_beat;

    assign a_chain[0] = a_q;
    assign b_chain[0] = b_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [15:0] step_a;
        logic [15:0] step_b;
        logic        lane_en;

        adler32_byte_step u_step (
            .a_in      (a_chain[i]),
            .b_in      (b_chain[i]),
            .data_byte (data[8*i +: 8]),
            .a_out     (step_a),
            .b_out     (step_b)
        );

        assign lane_en        = (remaining_q > 32'(i));
        assign a_chain[i + 1] = lane_en ? step_a : a_chain[i];
        assign b_chain[i + 1] = lane_en ? step_b : b_chain[i];
    end

    // A beat that covers everything left in the message closes it out.
    assign final_beat = (remaining_q <= 32'(LANES));

    // Next-state logic. checksum_valid is a registered pulse, so it defaults
    // low and only the closing event of a message raises it for one cycle.
    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        remaining_d      = remaining_q;
        checksum_d       = checksum_q;
        checksum_valid_d = 1'b0;
`ifdef ADLER32_MULTILANE_ERR_EN
        err_d            = 1'b0;
`endif

        case (state_q)
            IDLE: begin
`ifdef ADLER32_MULTILANE_ERR_EN
                err_d = data_valid;
`endif
                if (size_valid) begin
                    if (size != 32'd0) begin
                        remaining_d = size;
                        a_d         = A_INIT;
                        b_d         = 16'd0;
                        state_d     = DATA;
                    end else begin
                        // An empty message has the initial sums as its checksum.
                        checksum_d       = {16'd0, A_INIT};
                        checksum_valid_d = 1'b1;
                    end
                end
            end

            DATA: begin
`ifdef ADLER32_MULTILANE_ERR_EN
                err_d = size_valid;
`endif
                if (data_valid) begin
                    a_d = a_chain[LANES];
                    b_d = b_chain[LANES];
                    if (final_beat) begin
                        remaining_d      = 32'd0;
                        checksum_d       = {b_chain[LANES], a_chain[LANES]};
                        checksum_valid_d = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        remaining_d = remaining_q - 32'(LANES);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any
    // message in progress without ever pulsing checksum_valid.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            a_q              <= A_INIT;
            b_q              <= 16'd0;
            remaining_q      <= 32'd0;
            checksum_q       <= 32'd0;
            checksum_valid_q <= 1'b0;
`ifdef ADLER32_MULTILANE_ERR_EN
            err_q            <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            b_q              <= b_d;
            remaining_q      <= remaining_d;
            checksum_q       <= checksum_d;
            checksum_valid_q <= checksum_valid_d;
`ifdef ADLER32_MULTILANE_ERR_EN
            err_q            <= err_d;
`endif
        end
    end

    assign checksum_valid = checksum_valid_q;
    assign checksum       = checksum_q;
`ifdef ADLER32_MULTILANE_ERR_EN
    assign err            = err_q;
`endif

endmodule

// File: tb/tb_adler32_multilane.sv
// ---------------------------------------------------------------------------
// tb_adler32_multilane
// Directed bench driving a LANES=1 and a LANES=4 instance of
// adler32_multilane with hand-computed Adler-32 vectors:
//   "abc"       -> 0x024D0127
//   "Wikipedia" -> 0x11E60398
//   empty       -> 0x00000001
// Build option: define ADLER32_MULTILANE_ERR_EN to also exercise err.
// ---------------------------------------------------------------------------
module tb_adler32_multilane;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;

    logic        sv1, dv1, cv1;
    logic [31:0] sz1, cs1;
    logic [7:0]  d1;

    logic        sv4, dv4, cv4;
    logic [31:0] sz4, cs4;
    logic [31:0] d4;

`ifdef ADLER32_MULTILANE_ERR_EN
    logic        err1, err4;
`endif

    int total = 0;
    int bad   = 0;
    int pulses [2];
    int errs   [2];

    logic [7:0] abc_msg  [16];
    logic [7:0] wiki_msg [16];

    adler32_multilane #(.LANES(1)) dut1 (
        .clock          (clock),
        .rst_n          (rst_n),
        .size_valid     (sv1),
        .size           (sz1),
        .data_valid     (dv1),
        .data           (d1),
        .checksum_valid (cv1),
        .checksum       (cs1)
`ifdef ADLER32_MULTILANE_ERR_EN
        ,
        .err            (err1)
`endif
    );

    adler32_multilane #(.LANES(4)) dut4 (
        .clock          (clock),
        .rst_n          (rst_n),
        .size_valid     (sv4),
        .size           (sz4),
        .data_valid     (dv4),
        .data           (d4),
        .checksum_valid (cv4),
        .checksum       (cs4)
`ifdef ADLER32_MULTILANE_ERR_EN
        ,
        .err            (err4)
`endif
    );

    // Count every checksum_valid (and err) cycle so tests can confirm a
    // message produced exactly one pulse.
    always @(negedge clock) begin
        if (cv1 === 1'b1) pulses[0]++;
        if (cv4 === 1'b1) pulses[1]++;
`ifdef ADLER32_MULTILANE_ERR_EN
        if (err1 === 1'b1) errs[0]++;
        if (err4 === 1'b1) errs[1]++;
`endif
    end

    function automatic logic get_cv(input bit l4);
        return l4 ? cv4 : cv1;
    endfunction

    function automatic logic [31:0] get_cs(input bit l4);
        return l4 ? cs4 : cs1;
    endfunction

    task automatic set_size(input bit l4, input logic v, input logic [31:0] s);
        if (l4) begin sv4 = v; sz4 = s; end
        else    begin sv1 = v; sz1 = s; end
    endtask

    // Bytes beyond the end of the message are driven as 0xFF garbage.
    task automatic set_data(input bit l4, input logic v, input logic [7:0] msg [16],
                            input int len, input int idx);
        if (l4) begin
            dv4 = v;
            for (int j = 0; j < 4; j++)
                d4[8*j +: 8] = (idx + j < len) ? msg[idx + j] : 8'hFF;
        end else begin
            dv1 = v;
            d1  = (idx < len) ? msg[idx] : 8'hFF;
        end
    endtask

    // Drives one whole message. Returns at the negedge where checksum_valid
    // is due. size_now: assert size_valid at the current negedge instead of
    // waiting for the next one. sv_in_data: also raise size_valid on every
    // data beat.
    task automatic send_msg(input bit l4, input logic [7:0] msg [16], input int len,
                            input int gap, input bit size_now, input bit sv_in_data);
        int lanes;
        lanes = l4 ? 4 : 1;
        if (!size_now) @(negedge clock);
        set_size(l4, 1'b1, 32'(len));
        for (int idx = 0; idx < len; idx += lanes) begin
            @(negedge clock);
            set_size(l4, sv_in_data, 32'd5);
            set_data(l4, 1'b1, msg, len, idx);
            if (idx + lanes < len) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clock);
                    set_size(l4, 1'b0, 32'd0);
                    set_data(l4, 1'b0, msg, len, 0);
                end
            end
        end
        @(negedge clock);
        set_size(l4, 1'b0, 32'd0);
        set_data(l4, 1'b0, msg, len, len);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_size(1'b0, 1'b0, 32'd0); set_data(1'b0, 1'b0, abc_msg, 0, 0);
        set_size(1'b1, 1'b0, 32'd0); set_data(1'b1, 1'b0, abc_msg, 0, 0);
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (get_cv(k[0]) !== 1'b0) begin
                bad++; $display("[TB] FAIL reset_cv L%0d: got %b want 0", k*3+1, get_cv(k[0]));
            end
            total++;
            if (get_cs(k[0]) !== 32'h0) begin
                bad++; $display("[TB] FAIL reset_cs L%0d: got %h want 00000000", k*3+1, get_cs(k[0]));
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_size_zero(input bit l4);
        @(negedge clock);
        set_size(l4, 1'b1, 32'd0);
        @(negedge clock);
        set_size(l4, 1'b0, 32'd0);
        total++;
        if (get_cv(l4) !== 1'b1) begin
            bad++; $display("[TB] FAIL zero_cv L%0d: got %b want 1", l4 ? 4 : 1, get_cv(l4));
        end
        total++;
        if (get_cs(l4) !== 32'h00000001) begin
            bad++; $display("[TB] FAIL zero_cs L%0d: got %h want 00000001", l4 ? 4 : 1, get_cs(l4));
        end
        @(negedge clock);
        total++;
        if (get_cv(l4) !== 1'b0 || get_cs(l4) !== 32'h00000001) begin
            bad++; $display("[TB] FAIL zero_hold L%0d: got cv=%b cs=%h want cv=0 cs=00000001",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_abc(input bit l4);
        int p0;
        p0 = pulses[l4];
        send_msg(l4, abc_msg, 3, 0, 1'b0, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h024D0127) begin
            bad++; $display("[TB] FAIL abc L%0d: got cv=%b cs=%h want cv=1 cs=024d0127",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
        total++;
        if (pulses[l4] - p0 !== 1) begin
            bad++; $display("[TB] FAIL abc_pulses L%0d: got %0d want 1", l4 ? 4 : 1, pulses[l4] - p0);
        end
    endtask

    task automatic test_wikipedia(input bit l4);
        int p0;
        p0 = pulses[l4];
        send_msg(l4, wiki_msg, 9, 2, 1'b0, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h11E60398) begin
            bad++; $display("[TB] FAIL wiki L%0d: got cv=%b cs=%h want cv=1 cs=11e60398",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
        total++;
        if (pulses[l4] - p0 !== 1) begin
            bad++; $display("[TB] FAIL wiki_pulses L%0d: got %0d want 1", l4 ? 4 : 1, pulses[l4] - p0);
        end
    endtask

    task automatic test_back_to_back(input bit l4);
        int p0;
        p0 = pulses[l4];
        send_msg(l4, abc_msg, 3, 0, 1'b0, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h024D0127) begin
            bad++; $display("[TB] FAIL b2b_first L%0d: got cv=%b cs=%h want cv=1 cs=024d0127",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        send_msg(l4, wiki_msg, 9, 0, 1'b1, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h11E60398) begin
            bad++; $display("[TB] FAIL b2b_second L%0d: got cv=%b cs=%h want cv=1 cs=11e60398",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
        total++;
        if (pulses[l4] - p0 !== 2) begin
            bad++; $display("[TB] FAIL b2b_pulses L%0d: got %0d want 2", l4 ? 4 : 1, pulses[l4] - p0);
        end
    endtask

    task automatic test_reset_abort(input bit l4);
        int p0;
        p0 = pulses[l4];
        @(negedge clock);
        set_size(l4, 1'b1, 32'd9);
        for (int idx = 0; idx < 4; idx += (l4 ? 4 : 1)) begin
            @(negedge clock);
            set_size(l4, 1'b0, 32'd0);
            set_data(l4, 1'b1, wiki_msg, 9, idx);
        end
        @(negedge clock);
        set_data(l4, 1'b0, wiki_msg, 9, 0);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        total++;
        if (get_cs(l4) !== 32'h0) begin
            bad++; $display("[TB] FAIL abort_cs L%0d: got %h want 00000000", l4 ? 4 : 1, get_cs(l4));
        end
        repeat (4) @(negedge clock);
        total++;
        if (pulses[l4] - p0 !== 0) begin
            bad++; $display("[TB] FAIL abort_pulses L%0d: got %0d want 0", l4 ? 4 : 1, pulses[l4] - p0);
        end
        send_msg(l4, abc_msg, 3, 1, 1'b0, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h024D0127) begin
            bad++; $display("[TB] FAIL abort_then_abc L%0d: got cv=%b cs=%h want cv=1 cs=024d0127",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
    endtask

    // data_valid while idle (alone and together with size_valid) must not
    // disturb the following message.
    task automatic test_idle_data(input bit l4);
        @(negedge clock);
        set_data(l4, 1'b1, wiki_msg, 9, 0);
        send_msg(l4, abc_msg, 3, 0, 1'b0, 1'b0);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h024D0127) begin
            bad++; $display("[TB] FAIL idle_data L%0d: got cv=%b cs=%h want cv=1 cs=024d0127",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (2) @(negedge clock);
    endtask

    // size_valid on every data beat, including the last, is ignored.
    task automatic test_size_in_data(input bit l4);
        int e0;
        e0 = errs[l4];
        send_msg(l4, wiki_msg, 9, 1, 1'b0, 1'b1);
        total++;
        if (get_cv(l4) !== 1'b1 || get_cs(l4) !== 32'h11E60398) begin
            bad++; $display("[TB] FAIL size_in_data L%0d: got cv=%b cs=%h want cv=1 cs=11e60398",
                            l4 ? 4 : 1, get_cv(l4), get_cs(l4));
        end
        repeat (3) @(negedge clock);
`ifdef ADLER32_MULTILANE_ERR_EN
        total++;
        if (errs[l4] - e0 !== (l4 ? 3 : 9)) begin
            bad++; $display("[TB] FAIL err_pulses L%0d: got %0d want %0d",
                            l4 ? 4 : 1, errs[l4] - e0, l4 ? 3 : 9);
        end
`else
        total++;
        if (errs[l4] - e0 !== 0) begin
            bad++; $display("[TB] FAIL err_absent L%0d: got %0d want 0", l4 ? 4 : 1, errs[l4] - e0);
        end
`endif
    endtask

    initial begin
        pulses[0] = 0; pulses[1] = 0;
        errs[0]   = 0; errs[1]   = 0;
        for (int i = 0; i < 16; i++) begin
            abc_msg[i]  = 8'h00;
            wiki_msg[i] = 8'h00;
        end
        abc_msg[0] = 8'h61; abc_msg[1] = 8'h62; abc_msg[2] = 8'h63;
        wiki_msg[0] = 8'h57; wiki_msg[1] = 8'h69; wiki_msg[2] = 8'h6B;
        wiki_msg[3] = 8'h69; wiki_msg[4] = 8'h70; wiki_msg[5] = 8'h65;
        wiki_msg[6] = 8'h64; wiki_msg[7] = 8'h69; wiki_msg[8] = 8'h61;

        test_reset();
        for (int k = 0; k < 2; k++) begin
            test_size_zero(k[0]);
            test_abc(k[0]);
            test_wikipedia(k[0]);
            test_back_to_back(k[0]);
            test_reset_abort(k[0]);
            test_idle_data(k[0]);
            test_size_in_data(k[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
